// File: rtl/ddr3_xfer_sched.sv
// Arbitrates one write and one read requester, splits each request into datapath chunks and retries faulted chunks.
// ack/done/err/go are registered; go is held until the granted bsy is seen, and requesters hold req until ack.
module ddr3_xfer_sched #(
   parameter int CHUNK_WORDS = 256,
   parameter int MAX_RETRY   = 2,
   parameter int GO_TIMEOUT  = 16
) (
   input  logic        ui_clk,
   input  logic        rst,
   input  logic        i_phy_init_done,
   input  logic        i_wr_req,
   input  logic [15:0] i_wr_len,
   input  logic [11:0] i_wr_buf_addr,
   input  logic [25:0] i_wr_ddr3_addr,
   input  logic        i_rd_req,
   input  logic [15:0] i_rd_len,
   input  logic [11:0] i_rd_buf_addr,
   input  logic [25:0] i_rd_ddr3_addr,
   output logic        o_wr_ack,
   output logic        o_rd_ack,
   output logic        o_wr_done,
   output logic        o_rd_done,
   output logic        o_wr_err,
   output logic        o_rd_err,
   output logic        o_ibuf_go,
   output logic [11:0] o_ibuf_count,
   output logic [11:0] o_ibuf_start_addrb,
   output logic [25:0] o_ddr3_addra,
   input  logic        i_ibuf_bsy,
   input  logic        i_ibuf_ddr3_fault,
   output logic        o_obuf_go,
   output logic [11:0] o_obuf_count,
   output logic [11:0] o_obuf_start_addra,
   output logic [25:0] o_ddr3_addrb,
   input  logic        i_obuf_bsy,
   input  logic        i_obuf_ddr3_fault,
   output logic        o_busy,
   output logic [7:0]  o_fault_count
);
   localparam logic [15:0] LP_CHUNK     = 16'(CHUNK_WORDS);
   localparam logic [15:0] LP_TMO_LAST  = 16'(GO_TIMEOUT - 1);
   localparam logic [7:0]  LP_MAX_RETRY = 8'(MAX_RETRY);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_CHECK} state_t;

   state_t      r_state, w_state_n;
   logic        r_last_rd, w_last_rd_n;
   logic        r_rej, w_rej_n;
   logic [15:0] r_rem, w_rem_n;
   logic [11:0] r_baddr, w_baddr_n;
   logic [25:0] r_daddr, w_daddr_n;
   logic [7:0]  r_retry, w_retry_n;
   logic [15:0] r_tmo, w_tmo_n;
   logic        r_fault, w_fault_n;
   logic        w_go_n, w_ld, w_ack_n, w_done_n, w_err_n, w_fcnt_inc;
   logic        w_pick_rd, w_bsy, w_dp_fault, w_go, w_hold;
   logic [15:0] w_chunk, w_len;
   logic [11:0] w_nchunk;

   logic        r_wr_ack, r_rd_ack, r_wr_done, r_rd_done, r_wr_err, r_rd_err;
   logic        r_ibuf_go, r_obuf_go;
   logic [11:0] r_ib_cnt, r_ib_addr, r_ob_cnt, r_ob_addr;
   logic [25:0] r_ib_ddr, r_ob_ddr;
   logic [7:0]  r_fcnt;

   // Tie goes to the side that was not granted last.
   assign w_pick_rd  = i_rd_req & (~i_wr_req | ~r_last_rd);
   assign w_len      = w_pick_rd ? i_rd_len : i_wr_len;
   assign w_bsy      = r_last_rd ? i_obuf_bsy : i_ibuf_bsy;
   assign w_dp_fault = r_last_rd ? i_obuf_ddr3_fault : i_ibuf_ddr3_fault;
   assign w_go       = r_ibuf_go | r_obuf_go;
   assign w_hold     = r_wr_done | r_rd_done | r_wr_err | r_rd_err;
   assign w_chunk    = (r_rem > LP_CHUNK) ? LP_CHUNK : r_rem;
   assign w_nchunk   = (w_rem_n > LP_CHUNK) ? LP_CHUNK[11:0] : w_rem_n[11:0];

   always_comb begin
      w_state_n   = r_state;
      w_last_rd_n = r_last_rd;
      w_rej_n     = 1'b0;
      w_rem_n     = r_rem;
      w_baddr_n   = r_baddr;
      w_daddr_n   = r_daddr;
      w_retry_n   = r_retry;
      w_tmo_n     = r_tmo;
      w_fault_n   = r_fault;
      w_go_n      = 1'b0;
      w_ld        = 1'b0;
      w_ack_n     = 1'b0;
      w_done_n    = 1'b0;
      w_err_n     = 1'b0;
      w_fcnt_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_rej) begin
               w_err_n = 1'b1;
            end else if (i_phy_init_done && (i_wr_req || i_rd_req) && !w_hold) begin
               w_last_rd_n = w_pick_rd;
               w_ack_n     = 1'b1;
               w_rem_n     = w_len;
               w_baddr_n   = w_pick_rd ? i_rd_buf_addr : i_wr_buf_addr;
               w_daddr_n   = w_pick_rd ? i_rd_ddr3_addr : i_wr_ddr3_addr;
               w_retry_n   = 8'd0;
               if (w_len == 16'd0 || w_len[0]) w_rej_n = 1'b1;
               else                            w_state_n = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_go_n = 1'b1;
            if (!w_go) begin
               w_ld = 1'b1;
            end else if (w_bsy) begin
               w_go_n    = 1'b0;
               w_state_n = S_RUN;
            end else if (r_tmo == LP_TMO_LAST) begin
               w_go_n    = 1'b0;
               w_fault_n = 1'b1;
               w_state_n = S_CHECK;
            end else begin
               w_tmo_n = r_tmo + 16'd1;
            end
         end
         S_RUN: begin
            if (!w_bsy) begin
               w_fault_n = w_dp_fault;
               w_state_n = S_CHECK;
            end
         end
         S_CHECK: begin
            if (r_fault) begin
               w_fcnt_inc = 1'b1;
               if (r_retry < LP_MAX_RETRY) begin
                  w_retry_n = r_retry + 8'd1;
                  w_go_n    = 1'b1;
                  w_ld      = 1'b1;
                  w_state_n = S_ISSUE;
               end else begin
                  w_err_n   = 1'b1;
                  w_state_n = S_IDLE;
               end
            end else begin
               w_rem_n   = r_rem - w_chunk;
               w_baddr_n = r_baddr + w_chunk[11:0];
               w_daddr_n = r_daddr + 26'(w_chunk[15:1]);
               w_retry_n = 8'd0;
               if (w_rem_n == 16'd0) begin
                  w_done_n  = 1'b1;
                  w_state_n = S_IDLE;
               end else begin
                  w_go_n    = 1'b1;
                  w_ld      = 1'b1;
                  w_state_n = S_ISSUE;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase
      // Each new attempt restarts the bsy timeout and clears the latched fault.
      if (w_ld) begin
         w_tmo_n   = 16'd0;
         w_fault_n = 1'b0;
      end
   end

   always_ff @(posedge ui_clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_last_rd <= 1'b1;
         r_rej     <= 1'b0;
         r_rem     <= '0;
         r_baddr   <= '0;
         r_daddr   <= '0;
         r_retry   <= '0;
         r_tmo     <= '0;
         r_fault   <= 1'b0;
         r_wr_ack  <= 1'b0;
         r_rd_ack  <= 1'b0;
         r_wr_done <= 1'b0;
         r_rd_done <= 1'b0;
         r_wr_err  <= 1'b0;
         r_rd_err  <= 1'b0;
         r_ibuf_go <= 1'b0;
         r_obuf_go <= 1'b0;
         r_ib_cnt  <= '0;
         r_ib_addr <= '0;
         r_ib_ddr  <= '0;
         r_ob_cnt  <= '0;
         r_ob_addr <= '0;
         r_ob_ddr  <= '0;
         r_fcnt    <= '0;
      end else begin
         r_state   <= w_state_n;
         r_last_rd <= w_last_rd_n;
         r_rej     <= w_rej_n;
         r_rem     <= w_rem_n;
         r_baddr   <= w_baddr_n;
         r_daddr   <= w_daddr_n;
         r_retry   <= w_retry_n;
         r_tmo     <= w_tmo_n;
         r_fault   <= w_fault_n;
         r_wr_ack  <= w_ack_n  & ~w_last_rd_n;
         r_rd_ack  <= w_ack_n  &  w_last_rd_n;
         r_wr_done <= w_done_n & ~w_last_rd_n;
         r_rd_done <= w_done_n &  w_last_rd_n;
         r_wr_err  <= w_err_n  & ~w_last_rd_n;
         r_rd_err  <= w_err_n  &  w_last_rd_n;
         r_ibuf_go <= w_go_n   & ~w_last_rd_n;
         r_obuf_go <= w_go_n   &  w_last_rd_n;
         if (w_ld && !w_last_rd_n) begin
            r_ib_cnt  <= w_nchunk;
            r_ib_addr <= w_baddr_n;
            r_ib_ddr  <= w_daddr_n;
         end
         if (w_ld && w_last_rd_n) begin
            r_ob_cnt  <= w_nchunk;
            r_ob_addr <= w_baddr_n;
            r_ob_ddr  <= w_daddr_n;
         end
         if (w_fcnt_inc && r_fcnt != 8'hFF) r_fcnt <= r_fcnt + 8'd1;
      end
   end

   assign o_wr_ack           = r_wr_ack;
   assign o_rd_ack           = r_rd_ack;
   assign o_wr_done          = r_wr_done;
   assign o_rd_done          = r_rd_done;
   assign o_wr_err           = r_wr_err;
   assign o_rd_err           = r_rd_err;
   assign o_ibuf_go          = r_ibuf_go;
   assign o_ibuf_count       = r_ib_cnt;
   assign o_ibuf_start_addrb = r_ib_addr;
   assign o_ddr3_addra       = r_ib_ddr;
   assign o_obuf_go          = r_obuf_go;
   assign o_obuf_count       = r_ob_cnt;
   assign o_obuf_start_addra = r_ob_addr;
   assign o_ddr3_addrb       = r_ob_ddr;
   assign o_busy             = (r_state != S_IDLE);
   assign o_fault_count      = r_fcnt;
endmodule

// File: tb/tb_ddr3_xfer_sched.sv
// Directed bench for ddr3_xfer_sched with bench-side datapath responders and an output monitor.
`timescale 1ns/1ps
module tb_ddr3_xfer_sched;
   logic        ui_clk, rst, i_phy_init_done;
   logic        i_wr_req, i_rd_req;
   logic [15:0] i_wr_len, i_rd_len;
   logic [11:0] i_wr_buf_addr, i_rd_buf_addr;
   logic [25:0] i_wr_ddr3_addr, i_rd_ddr3_addr;
   logic        o_wr_ack, o_rd_ack, o_wr_done, o_rd_done, o_wr_err, o_rd_err;
   logic        o_ibuf_go, o_obuf_go, o_busy;
   logic [11:0] o_ibuf_count, o_ibuf_start_addrb, o_obuf_count, o_obuf_start_addra;
   logic [25:0] o_ddr3_addra, o_ddr3_addrb;
   logic        i_ibuf_bsy, i_ibuf_ddr3_fault, i_obuf_bsy, i_obuf_ddr3_fault;
   logic [7:0]  o_fault_count;

   ddr3_xfer_sched #(.CHUNK_WORDS(256), .MAX_RETRY(2), .GO_TIMEOUT(16)) dut (
      .ui_clk(ui_clk), .rst(rst), .i_phy_init_done(i_phy_init_done),
      .i_wr_req(i_wr_req), .i_wr_len(i_wr_len), .i_wr_buf_addr(i_wr_buf_addr), .i_wr_ddr3_addr(i_wr_ddr3_addr),
      .i_rd_req(i_rd_req), .i_rd_len(i_rd_len), .i_rd_buf_addr(i_rd_buf_addr), .i_rd_ddr3_addr(i_rd_ddr3_addr),
      .o_wr_ack(o_wr_ack), .o_rd_ack(o_rd_ack), .o_wr_done(o_wr_done), .o_rd_done(o_rd_done),
      .o_wr_err(o_wr_err), .o_rd_err(o_rd_err),
      .o_ibuf_go(o_ibuf_go), .o_ibuf_count(o_ibuf_count), .o_ibuf_start_addrb(o_ibuf_start_addrb),
      .o_ddr3_addra(o_ddr3_addra), .i_ibuf_bsy(i_ibuf_bsy), .i_ibuf_ddr3_fault(i_ibuf_ddr3_fault),
      .o_obuf_go(o_obuf_go), .o_obuf_count(o_obuf_count), .o_obuf_start_addra(o_obuf_start_addra),
      .o_ddr3_addrb(o_ddr3_addrb), .i_obuf_bsy(i_obuf_bsy), .i_obuf_ddr3_fault(i_obuf_ddr3_fault),
      .o_busy(o_busy), .o_fault_count(o_fault_count)
   );

   initial begin
      ui_clk = 1'b0;
      forever #5 ui_clk = ~ui_clk;
   end

   int n_checks = 0, n_pass = 0;
   int wr_ack_c = 0, rd_ack_c = 0, wr_done_c = 0, rd_done_c = 0, wr_err_c = 0, rd_err_c = 0;
   int overlap_c = 0, ig_len_cur = 0, ig_len_last = 0, og_len_cur = 0;
   bit prev_ig = 1'b0, prev_og = 1'b0;
   int ib_cnt_q[$], ib_addr_q[$], ib_ddr_q[$], ob_cnt_q[$], ob_addr_q[$], ob_ddr_q[$], order_q[$];

   int         ib_bsy_len = 10, ob_bsy_len = 10;
   bit         ib_never = 1'b0;
   logic [7:0] ib_mask = '0, ob_mask = '0;
   int         ib_att = 0, ob_att = 0, ib_base = 0, ob_base = 0, ib_idx, ob_idx;

   // Datapath models: raise bsy the cycle after go is seen, hold it, then report the configured fault.
   initial begin
      i_ibuf_bsy = 1'b0; i_ibuf_ddr3_fault = 1'b0;
      forever begin
         @(posedge ui_clk); #1;
         if (o_ibuf_go && !i_ibuf_bsy && !ib_never) begin
            ib_idx = ib_att - ib_base;
            ib_att++;
            i_ibuf_ddr3_fault = 1'b0;
            i_ibuf_bsy = 1'b1;
            repeat (ib_bsy_len) @(posedge ui_clk);
            #1;
            i_ibuf_ddr3_fault = (ib_idx < 8) ? ib_mask[ib_idx] : 1'b0;
            i_ibuf_bsy = 1'b0;
         end
      end
   end

   initial begin
      i_obuf_bsy = 1'b0; i_obuf_ddr3_fault = 1'b0;
      forever begin
         @(posedge ui_clk); #1;
         if (o_obuf_go && !i_obuf_bsy) begin
            ob_idx = ob_att - ob_base;
            ob_att++;
            i_obuf_ddr3_fault = 1'b0;
            i_obuf_bsy = 1'b1;
            repeat (ob_bsy_len) @(posedge ui_clk);
            #1;
            i_obuf_ddr3_fault = (ob_idx < 8) ? ob_mask[ob_idx] : 1'b0;
            i_obuf_bsy = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge ui_clk); #2;
         if (o_ibuf_go && !prev_ig) begin
            ib_cnt_q.push_back(int'(o_ibuf_count)); ib_addr_q.push_back(int'(o_ibuf_start_addrb));
            ib_ddr_q.push_back(int'(o_ddr3_addra));
         end
         if (o_obuf_go && !prev_og) begin
            ob_cnt_q.push_back(int'(o_obuf_count)); ob_addr_q.push_back(int'(o_obuf_start_addra));
            ob_ddr_q.push_back(int'(o_ddr3_addrb));
         end
         if (o_ibuf_go) ig_len_cur = prev_ig ? ig_len_cur + 1 : 1;
         else if (prev_ig) ig_len_last = ig_len_cur;
         if (o_obuf_go) og_len_cur = prev_og ? og_len_cur + 1 : 1;
         if (o_ibuf_go && o_obuf_go) overlap_c++;
         if (o_wr_ack) begin wr_ack_c++; order_q.push_back(0); end
         if (o_rd_ack) begin rd_ack_c++; order_q.push_back(1); end
         if (o_wr_done) wr_done_c++;
         if (o_rd_done) rd_done_c++;
         if (o_wr_err) wr_err_c++;
         if (o_rd_err) rd_err_c++;
         prev_ig = o_ibuf_go;
         prev_og = o_obuf_go;
      end
   end

   task automatic apply_reset();
      @(negedge ui_clk); rst = 1'b1;
      repeat (2) @(negedge ui_clk);
      rst = 1'b0;
   endtask

   task automatic wr_request(input int len, input int baddr, input int daddr, output bit ok);
      @(negedge ui_clk);
      i_wr_len = 16'(len); i_wr_buf_addr = 12'(baddr); i_wr_ddr3_addr = 26'(daddr); i_wr_req = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge ui_clk);
         if (o_wr_ack) ok = 1'b1;
      end
      i_wr_req = 1'b0;
   endtask

   task automatic rd_request(input int len, input int baddr, input int daddr, output bit ok);
      @(negedge ui_clk);
      i_rd_len = 16'(len); i_rd_buf_addr = 12'(baddr); i_rd_ddr3_addr = 26'(daddr); i_rd_req = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge ui_clk);
         if (o_rd_ack) ok = 1'b1;
      end
      i_rd_req = 1'b0;
   endtask

   task automatic wait_end(input bit rd, output bit ok, output bit busy_then);
      ok = 1'b0; busy_then = 1'b1;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge ui_clk);
         if (rd ? (o_rd_done || o_rd_err) : (o_wr_done || o_wr_err)) begin
            ok = 1'b1; busy_then = o_busy;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({o_wr_ack, o_rd_ack, o_wr_done, o_rd_done, o_wr_err, o_rd_err, o_ibuf_go, o_obuf_go, o_busy} !== 9'd0)
         $display("FAIL reset_ctrl: got %b, want 0", {o_wr_ack, o_rd_ack, o_wr_done, o_rd_done, o_wr_err,
                  o_rd_err, o_ibuf_go, o_obuf_go, o_busy});
      else n_pass++;
      n_checks++;
      if ({o_ibuf_count, o_ibuf_start_addrb, o_ddr3_addra, o_obuf_count, o_obuf_start_addra, o_ddr3_addrb,
           o_fault_count} !== '0)
         $display("FAIL reset_cmd: got %h, want 0", {o_ibuf_count, o_ibuf_start_addrb, o_ddr3_addra,
                  o_obuf_count, o_obuf_start_addra, o_ddr3_addrb, o_fault_count});
      else n_pass++;
   endtask

   task automatic test_fairness();
      int base, wd, rd;
      base = order_q.size(); wd = wr_done_c; rd = rd_done_c;
      @(negedge ui_clk);
      i_wr_len = 16'd8; i_wr_buf_addr = 12'h010; i_wr_ddr3_addr = 26'h10;
      i_rd_len = 16'd8; i_rd_buf_addr = 12'h020; i_rd_ddr3_addr = 26'h20;
      i_wr_req = 1'b1; i_rd_req = 1'b1;
      for (int i = 0; i < 400 && order_q.size() < base + 4; i++) @(negedge ui_clk);
      i_wr_req = 1'b0; i_rd_req = 1'b0;
      for (int i = 0; i < 400 && rd_done_c < rd + 2; i++) @(negedge ui_clk);
      n_checks++;
      if (order_q.size() - base !== 4) $display("FAIL fair_acks: got %0d, want 4", order_q.size() - base);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         int got;
         got = (base + i < order_q.size()) ? order_q[base + i] : -1;
         n_checks++;
         if (got !== i % 2) $display("FAIL fair_order[%0d]: got %0d, want %0d (0=W 1=R)", i, got, i % 2);
         else n_pass++;
      end
      n_checks++;
      if ({wr_done_c - wd, rd_done_c - rd} !== {32'd2, 32'd2})
         $display("FAIL fair_done: got wr %0d rd %0d, want 2 2", wr_done_c - wd, rd_done_c - rd);
      else n_pass++;
      n_checks++;
      if (overlap_c !== 0) $display("FAIL fair_overlap: got %0d, want 0", overlap_c);
      else n_pass++;
   endtask

   task automatic test_chunked_write();
      int exp_cnt[3] = '{256, 256, 88};
      int exp_adr[3] = '{'hF00, 'h000, 'h100};
      int exp_ddr[3] = '{'h100, 'h180, 'h200};
      int base, wd, we;
      bit ok, busy_then;
      base = ib_cnt_q.size(); wd = wr_done_c; we = wr_err_c;
      wr_request(600, 'hF00, 'h100, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL chunk_ack: got %0d, want 1", ok); else n_pass++;
      @(negedge ui_clk);
      n_checks++;
      if (o_ibuf_go !== 1'b1) $display("FAIL chunk_go_after_ack: got %b, want 1", o_ibuf_go); else n_pass++;
      wait_end(1'b0, ok, busy_then);
      n_checks++;
      if ({ok, busy_then} !== 2'b10) $display("FAIL chunk_end: got ended=%0d busy=%0d, want 1 0", ok, busy_then);
      else n_pass++;
      repeat (2) @(negedge ui_clk);
      n_checks++;
      if (ib_cnt_q.size() - base !== 3) $display("FAIL chunk_gos: got %0d, want 3", ib_cnt_q.size() - base);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         int c, a, d;
         c = (base + i < ib_cnt_q.size()) ? ib_cnt_q[base + i] : -1;
         a = (base + i < ib_cnt_q.size()) ? ib_addr_q[base + i] : -1;
         d = (base + i < ib_cnt_q.size()) ? ib_ddr_q[base + i] : -1;
         n_checks++;
         if ({c, a, d} !== {exp_cnt[i], exp_adr[i], exp_ddr[i]})
            $display("FAIL chunk_cmd[%0d]: got cnt %0d buf %h ddr %h, want cnt %0d buf %h ddr %h",
                     i, c, a, d, exp_cnt[i], exp_adr[i], exp_ddr[i]);
         else n_pass++;
      end
      n_checks++;
      if ({wr_done_c - wd, wr_err_c - we} !== {32'd1, 32'd0})
         $display("FAIL chunk_done: got done %0d err %0d, want 1 0", wr_done_c - wd, wr_err_c - we);
      else n_pass++;
   endtask

   task automatic test_rejects();
      int gi, go, dw;
      bit ok;
      gi = ib_cnt_q.size(); go = ob_cnt_q.size(); dw = wr_done_c;
      wr_request(7, 'h0, 'h0, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL rej7_ack: got %0d, want 1", ok); else n_pass++;
      @(negedge ui_clk);
      n_checks++;
      if ({o_wr_err, o_ibuf_go} !== 2'b10) $display("FAIL rej7_err: got err=%b go=%b, want 1 0", o_wr_err, o_ibuf_go);
      else n_pass++;
      rd_request(0, 'h0, 'h0, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL rej0_ack: got %0d, want 1", ok); else n_pass++;
      @(negedge ui_clk);
      n_checks++;
      if (o_rd_err !== 1'b1) $display("FAIL rej0_err: got %b, want 1", o_rd_err); else n_pass++;
      repeat (5) @(negedge ui_clk);
      n_checks++;
      if ({ib_cnt_q.size() - gi, ob_cnt_q.size() - go, wr_done_c - dw} !== {32'd0, 32'd0, 32'd0})
         $display("FAIL rej_no_go: got %0d %0d %0d, want 0 0 0", ib_cnt_q.size() - gi, ob_cnt_q.size() - go,
                  wr_done_c - dw);
      else n_pass++;
      // Calibration not done: the request must be ignored.
      @(negedge ui_clk);
      gi = wr_ack_c;
      i_phy_init_done = 1'b0; i_wr_len = 16'd8; i_wr_req = 1'b1;
      repeat (20) @(negedge ui_clk);
      n_checks++;
      if ({wr_ack_c - gi, 31'd0, o_busy} !== {32'd0, 32'd0})
         $display("FAIL phy_no_ack: got acks %0d busy %b, want 0 0", wr_ack_c - gi, o_busy);
      else n_pass++;
      i_wr_req = 1'b0;
      @(negedge ui_clk);
      i_phy_init_done = 1'b1;
   endtask

   task automatic test_retry(input bit exhaust);
      int base, dr, er;
      bit ok, busy_then;
      apply_reset();
      ob_mask = exhaust ? 8'b111 : 8'b011;
      ob_base = ob_att;
      base = ob_cnt_q.size(); dr = rd_done_c; er = rd_err_c;
      rd_request(16, 'h040, 'h2000, ok);
      wait_end(1'b1, ok, busy_then);
      repeat (2) @(negedge ui_clk);
      n_checks++;
      if ({ok, busy_then} !== 2'b10)
         $display("FAIL retry%0d_end: got ended=%0d busy=%0d, want 1 0", exhaust, ok, busy_then);
      else n_pass++;
      n_checks++;
      if ({rd_done_c - dr, rd_err_c - er} !== (exhaust ? {32'd0, 32'd1} : {32'd1, 32'd0}))
         $display("FAIL retry%0d_result: got done %0d err %0d", exhaust, rd_done_c - dr, rd_err_c - er);
      else n_pass++;
      n_checks++;
      if (o_fault_count !== (exhaust ? 8'd3 : 8'd2))
         $display("FAIL retry%0d_faults: got %0d, want %0d", exhaust, o_fault_count, exhaust ? 3 : 2);
      else n_pass++;
      n_checks++;
      if (ob_cnt_q.size() - base !== 3) $display("FAIL retry%0d_gos: got %0d, want 3", exhaust, ob_cnt_q.size() - base);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         int c, a, d;
         c = (base + i < ob_cnt_q.size()) ? ob_cnt_q[base + i] : -1;
         a = (base + i < ob_cnt_q.size()) ? ob_addr_q[base + i] : -1;
         d = (base + i < ob_cnt_q.size()) ? ob_ddr_q[base + i] : -1;
         n_checks++;
         if ({c, a, d} !== {32'd16, 32'h040, 32'h2000})
            $display("FAIL retry%0d_cmd[%0d]: got cnt %0d buf %h ddr %h, want 16 040 2000", exhaust, i, c, a, d);
         else n_pass++;
      end
      ob_mask = '0;
   endtask

   task automatic test_timeout();
      int base, we;
      bit ok, busy_then;
      apply_reset();
      ib_never = 1'b1;
      base = ib_cnt_q.size(); we = wr_err_c;
      wr_request(8, 'h0, 'h0, ok);
      wait_end(1'b0, ok, busy_then);
      repeat (2) @(negedge ui_clk);
      ib_never = 1'b0;
      n_checks++;
      if (ig_len_last !== 16) $display("FAIL tmo_go_len: got %0d, want 16", ig_len_last); else n_pass++;
      n_checks++;
      if ({ib_cnt_q.size() - base, wr_err_c - we} !== {32'd3, 32'd1})
         $display("FAIL tmo_attempts: got gos %0d err %0d, want 3 1", ib_cnt_q.size() - base, wr_err_c - we);
      else n_pass++;
      n_checks++;
      if (o_fault_count !== 8'd3) $display("FAIL tmo_faults: got %0d, want 3", o_fault_count); else n_pass++;
   endtask

   task automatic test_reset_midrun();
      int wd, we, base;
      bit ok, busy_then;
      wd = wr_done_c; we = wr_err_c;
      wr_request(8, 'h010, 'h20, ok);
      repeat (4) @(negedge ui_clk);
      n_checks++;
      if ({o_busy, o_ibuf_go, i_ibuf_bsy} !== 3'b101)
         $display("FAIL mid_in_run: got busy/go/bsy %b, want 101", {o_busy, o_ibuf_go, i_ibuf_bsy});
      else n_pass++;
      rst = 1'b1;
      @(negedge ui_clk);
      n_checks++;
      if ({o_wr_ack, o_wr_done, o_wr_err, o_ibuf_go, o_busy, o_ibuf_count, o_ibuf_start_addrb, o_ddr3_addra,
           o_fault_count} !== '0)
         $display("FAIL mid_reset_outputs: got busy %b cnt %0d buf %h ddr %h faults %0d", o_busy, o_ibuf_count,
                  o_ibuf_start_addrb, o_ddr3_addra, o_fault_count);
      else n_pass++;
      rst = 1'b0;
      repeat (20) @(negedge ui_clk);
      n_checks++;
      if ({wr_done_c - wd, wr_err_c - we} !== {32'd0, 32'd0})
         $display("FAIL mid_no_end: got done %0d err %0d, want 0 0", wr_done_c - wd, wr_err_c - we);
      else n_pass++;
      base = ib_cnt_q.size();
      wr_request(8, 'h030, 'h40, ok);
      wait_end(1'b0, ok, busy_then);
      repeat (2) @(negedge ui_clk);
      n_checks++;
      if ({ok, wr_done_c - wd} !== {1'b1, 32'd1})
         $display("FAIL mid_after_done: got ended %0d done %0d, want 1 1", ok, wr_done_c - wd);
      else n_pass++;
      n_checks++;
      if ((ib_cnt_q.size() > base ? {ib_cnt_q[base], ib_addr_q[base]} : {32'hFFFFFFFF, 32'hFFFFFFFF})
          !== {32'd8, 32'h030})
         $display("FAIL mid_after_cmd: got %0d gos, want one with cnt 8 buf 030", ib_cnt_q.size() - base);
      else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_phy_init_done = 1'b1;
      i_wr_req = 1'b0; i_rd_req = 1'b0;
      i_wr_len = '0; i_wr_buf_addr = '0; i_wr_ddr3_addr = '0;
      i_rd_len = '0; i_rd_buf_addr = '0; i_rd_ddr3_addr = '0;
      test_reset();
      test_fairness();
      test_chunked_write();
      test_rejects();
      test_retry(1'b0);
      test_retry(1'b1);
      test_timeout();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ddr3_xfer_sched.md
# ddr3_xfer_sched

Transfer scheduler in front of the DDR3 buffer-bridge datapath. It arbitrates between one write requester (buffer → DDR3) and one read requester (DDR3 → buffer) and splits each request into chunks of at most CHUNK_WORDS 32-bit words. It sequences the datapath's go/bsy handshake per chunk, retries faulted chunks, and reports done or error per request. It sits between host-side command logic and the bridge's ibuf/obuf go interfaces, all in the ui_clk domain.

## Interface
- CHUNK_WORDS, 256, maximum words per datapath transaction; even, 2..2048
- MAX_RETRY, 2, reissues allowed per chunk after a fault
- GO_TIMEOUT, 16, cycles to wait for bsy to rise before the attempt counts as a fault
- ui_clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_phy_init_done  in  1  DDR3 calibrated; gates request acceptance only
- i_wr_req / i_rd_req  in  1  request level, held until matching ack
- i_wr_len / i_rd_len  in  16  length in 32-bit words
- i_wr_buf_addr / i_rd_buf_addr  in  12  buffer start word address
- i_wr_ddr3_addr / i_rd_ddr3_addr  in  26  DDR3 start address, units of 2 words
- o_wr_ack / o_rd_ack  out  1  1-cycle pulse; request fields captured
- o_wr_done / o_rd_done  out  1  1-cycle pulse; all chunks succeeded
- o_wr_err / o_rd_err  out  1  1-cycle pulse; request rejected or retries exhausted
- o_ibuf_go, o_ibuf_count[11:0], o_ibuf_start_addrb[11:0], o_ddr3_addra[25:0]  out  write-chunk command
- i_ibuf_bsy, i_ibuf_ddr3_fault  in  1  write-chunk status
- o_obuf_go, o_obuf_count[11:0], o_obuf_start_addra[11:0], o_ddr3_addrb[25:0]  out  read-chunk command
- i_obuf_bsy, i_obuf_ddr3_fault  in  1  read-chunk status
- o_busy  out  1  high in every state except S_IDLE
- o_fault_count  out  8  saturating count of faulted attempts since reset

## Operation
- Reset: every output is 0. last_grant = READ, so the write side wins the first tie.
- S_IDLE: acceptance requires i_phy_init_done=1 and at least one req.
  - If only one req is high, grant it. If both are high, grant the side opposite last_grant.
  - Capture len, buf_addr, and ddr3_addr into rem, baddr, daddr. Set retry=0, update last_grant, and pulse ack.
  - If len==0 or len[0]==1: pulse err one cycle after ack, no datapath activity, stay in S_IDLE.
  - Otherwise go to S_ISSUE.
- S_ISSUE:
  - chunk = min(rem, CHUNK_WORDS).
  - Drive the granted side's count=chunk, start_addr=baddr, ddr3_addr=daddr, and go=1. The other side's go stays 0.
  - Hold go until the granted bsy is 1, then drop go and go to S_RUN.
  - If bsy stays 0 for GO_TIMEOUT cycles, drop go and treat the attempt as a fault (S_CHECK).
- S_RUN: wait for the granted bsy to be 0, then go to S_CHECK. The datapath fault flag is valid in that cycle.
- S_CHECK on fault:
  - o_fault_count increments, saturating at 255.
  - If retry < MAX_RETRY: retry++ and return to S_ISSUE with identical chunk, baddr, and daddr.
  - Otherwise pulse err and go to S_IDLE. No done pulse.
- S_CHECK on success:
  - rem -= chunk; baddr = (baddr + chunk) mod 4096; daddr = (daddr + chunk/2) mod 2^26; retry=0.
  - If rem==0, pulse done and go to S_IDLE; otherwise go to S_ISSUE.
- Arbitration granularity is the whole request; a granted request runs to done or err before the other side is considered.
- Command outputs (count, addrs) hold their last value outside S_ISSUE. Only go is qualifying.
- Falling i_phy_init_done mid-request is ignored; the datapath fault/timeout path covers it.

## Timing
- Ack is registered, high in the cycle after the S_IDLE decision. Requester may drop req the cycle after ack.
- go rises in the cycle after ack; it also rises one cycle after S_CHECK for each subsequent chunk or retry.
- go falls in the cycle after bsy is sampled 1.
- done/err are registered, high exactly one cycle, coincident with the return to S_IDLE.
- Minimum S_CHECK → next go is 1 cycle; next request acceptance is no sooner than 1 cycle after done/err.
- rst mid-request: outputs 0 on the next cycle, no done/err, request is lost, and o_fault_count returns to 0.

## Test plan
- Chunked write:
  - Stimulus: CHUNK_WORDS=256, write len=600, buf 0xF00, ddr3 0x100; bsy 1 for 10 cycles each chunk, no fault.
  - Response: three ibuf go's with counts 256/256/88, buf addrs 0xF00/0x000/0x100, ddr3 0x100/0x180/0x200, then a single o_wr_done.
- Fairness: wr_req and rd_req high together, for two requests each side, len=8 → order W,R,W,R; obuf_go never overlaps ibuf_go.
- Retry success: read len=16 with fault on attempts 1–2 → three identical obuf commands, o_rd_done, o_fault_count=2.
- Retry exhausted: fault on three attempts → o_rd_err, no done, o_fault_count=3, S_IDLE.
- Timeout and rejects:
  - bsy never rises → go drops after 16 cycles and the attempt counts as a fault.
  - len=7 → ack then err, no go.
  - i_phy_init_done=0 → no ack.
- Reset: rst during S_RUN → all outputs 0 next cycle; a subsequent write len=8 completes normally.
